// File: rtl/disp_param_sched.sv
// Display parameter scheduler: buffers producer updates in shadow registers and
// commits them to the display outputs on a vertical-blanking rise, plus view toggling.
module disp_param_sched #(
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned AUTO_SWITCH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblank,
  input  logic        zx_valid,
  output logic        zx_ready,
  input  logic [15:0] zx_p_in,
  input  logic [15:0] zx_f_in,
  input  logic        fzx_valid,
  output logic        fzx_ready,
  input  logic [15:0] fzx_p_in,
  input  logic [15:0] fzx_f_in,
  input  logic [63:0] fzx_h_in,
  output logic [15:0] zx_P,
  output logic [15:0] zx_F,
  output logic [15:0] fzx_P,
  output logic [15:0] fzx_F,
  output logic [15:0] fzx_2_F,
  output logic [15:0] fzx_3_F,
  output logic [15:0] fzx_4_F,
  output logic [15:0] fzx_5_F,
  output logic        switch,
  output logic        commit
);

  typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_t;

  localparam logic [7:0] FRAME_LAST = 8'(HOLD_FRAMES - 1);

  state_t      state_q, state_d;
  logic        vblank_q;
  logic        rise;
  logic [15:0] zx_p_q, zx_f_q, fzx_p_q, fzx_f_q;
  logic [63:0] fzx_h_q;
  logic        zx_pend_q, fzx_pend_q;
  logic        last_fzx_q;
  logic [7:0]  frame_q;
  logic        switch_q, commit_q;
  logic [15:0] zx_P_q, zx_F_q, fzx_P_q, fzx_F_q;
  logic [63:0] fzx_h_out_q;
  logic        accept_ok, zx_elig, fzx_elig, zx_grant, fzx_grant;
  logic        zx_take, fzx_take;

  assign rise = vblank & ~vblank_q;

  // Round-robin between the two producers; last_fzx_q favours zx on a tie.
  assign accept_ok = (state_q == IDLE) || (state_q == ARMED);
  assign zx_elig   = zx_valid & ~zx_pend_q;
  assign fzx_elig  = fzx_valid & ~fzx_pend_q;
  assign zx_grant  = zx_elig & (~fzx_elig | last_fzx_q);
  assign fzx_grant = fzx_elig & ~zx_grant;
  assign zx_ready  = ~rst & accept_ok & zx_grant;
  assign fzx_ready = ~rst & accept_ok & fzx_grant;
  assign zx_take   = zx_valid & zx_ready;
  assign fzx_take  = fzx_valid & fzx_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (zx_pend_q || fzx_pend_q) state_d = ARMED;
      ARMED:   if (rise) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vblank_q    <= 1'b1;
      zx_p_q      <= '0;
      zx_f_q      <= '0;
      fzx_p_q     <= '0;
      fzx_f_q     <= '0;
      fzx_h_q     <= '0;
      zx_pend_q   <= 1'b0;
      fzx_pend_q  <= 1'b0;
      last_fzx_q  <= 1'b1;
      frame_q     <= '0;
      switch_q    <= 1'b1;
      commit_q    <= 1'b0;
      zx_P_q      <= '0;
      zx_F_q      <= '0;
      fzx_P_q     <= '0;
      fzx_F_q     <= '0;
      fzx_h_out_q <= '0;
    end else begin
      state_q  <= state_d;
      vblank_q <= vblank;
      commit_q <= (state_q == COMMIT);

      if (zx_take) begin
        zx_p_q     <= zx_p_in;
        zx_f_q     <= zx_f_in;
        zx_pend_q  <= 1'b1;
        last_fzx_q <= 1'b0;
      end
      if (fzx_take) begin
        fzx_p_q    <= fzx_p_in;
        fzx_f_q    <= fzx_f_in;
        fzx_h_q    <= fzx_h_in;
        fzx_pend_q <= 1'b1;
        last_fzx_q <= 1'b1;
      end

      // No transfer can be accepted in COMMIT, so clearing pending here never races a capture.
      if (state_q == COMMIT) begin
        if (zx_pend_q) begin
          zx_P_q <= zx_p_q;
          zx_F_q <= zx_f_q;
        end
        if (fzx_pend_q) begin
          fzx_P_q     <= fzx_p_q;
          fzx_F_q     <= fzx_f_q;
          fzx_h_out_q <= fzx_h_q;
        end
        zx_pend_q  <= 1'b0;
        fzx_pend_q <= 1'b0;
      end

      if (rise) begin
        if (frame_q == FRAME_LAST) begin
          frame_q <= '0;
          if (AUTO_SWITCH != 0) switch_q <= ~switch_q;
        end else begin
          frame_q <= frame_q + 8'd1;
        end
      end
    end
  end

  assign zx_P    = zx_P_q;
  assign zx_F    = zx_F_q;
  assign fzx_P   = fzx_P_q;
  assign fzx_F   = fzx_F_q;
  assign fzx_2_F = fzx_h_out_q[15:0];
  assign fzx_3_F = fzx_h_out_q[31:16];
  assign fzx_4_F = fzx_h_out_q[47:32];
  assign fzx_5_F = fzx_h_out_q[63:48];
  assign switch  = switch_q;
  assign commit  = commit_q;

endmodule

// File: tb/tb_disp_param_sched.sv
// Scoreboard bench for disp_param_sched: expected display vectors are queued when
// transfers are issued and compared by a monitor whenever commit pulses.
module tb_disp_param_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblank;
  logic        zxValid, fzxValid;
  logic [15:0] zxPIn, zxFIn, fzxPIn, fzxFIn;
  logic [63:0] fzxHIn;
  logic        zxReady, fzxReady, switchOut, commitOut;
  logic [15:0] zxP, zxF, fzxP, fzxF, fzx2F, fzx3F, fzx4F, fzx5F;
  logic        zxReady0, fzxReady0, switch0, commit0;
  logic [15:0] outs0 [8];

  logic [127:0] expQ [$];
  int checks = 0;
  int errors = 0;

  localparam logic [63:0] H1 = {16'd3, 16'd0, 16'd40, 16'd0};
  localparam logic [63:0] H2 = 64'h0004_0003_0002_0001;

  disp_param_sched #(.HOLD_FRAMES(3), .AUTO_SWITCH(1)) dut (
    .clk(clk), .rst(rst), .vblank(vblank),
    .zx_valid(zxValid), .zx_ready(zxReady), .zx_p_in(zxPIn), .zx_f_in(zxFIn),
    .fzx_valid(fzxValid), .fzx_ready(fzxReady), .fzx_p_in(fzxPIn), .fzx_f_in(fzxFIn),
    .fzx_h_in(fzxHIn),
    .zx_P(zxP), .zx_F(zxF), .fzx_P(fzxP), .fzx_F(fzxF),
    .fzx_2_F(fzx2F), .fzx_3_F(fzx3F), .fzx_4_F(fzx4F), .fzx_5_F(fzx5F),
    .switch(switchOut), .commit(commitOut)
  );

  disp_param_sched #(.HOLD_FRAMES(3), .AUTO_SWITCH(0)) dut0 (
    .clk(clk), .rst(rst), .vblank(vblank),
    .zx_valid(zxValid), .zx_ready(zxReady0), .zx_p_in(zxPIn), .zx_f_in(zxFIn),
    .fzx_valid(fzxValid), .fzx_ready(fzxReady0), .fzx_p_in(fzxPIn), .fzx_f_in(fzxFIn),
    .fzx_h_in(fzxHIn),
    .zx_P(outs0[0]), .zx_F(outs0[1]), .fzx_P(outs0[2]), .fzx_F(outs0[3]),
    .fzx_2_F(outs0[4]), .fzx_3_F(outs0[5]), .fzx_4_F(outs0[6]), .fzx_5_F(outs0[7]),
    .switch(switch0), .commit(commit0)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [127:0] packExp(input logic [15:0] a, b, c, d, e, f, g, h);
    return {a, b, c, d, e, f, g, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic zv, input logic [15:0] zp, zf,
                               input logic fv, input logic [15:0] fp, ff,
                               input logic [63:0] fh, input logic vb);
    zxValid  = zv;
    zxPIn    = zp;
    zxFIn    = zf;
    fzxValid = fv;
    fzxPIn   = fp;
    fzxFIn   = ff;
    fzxHIn   = fh;
    vblank   = vb;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1, 16'd1, 16'd1, 1, 16'd1, 16'd1, 64'd0, 0);
    checkOutput("readyInReset zx", zxReady, 0);
    checkOutput("readyInReset fzx", fzxReady, 0);
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    checkOutput("reset zxP", zxP, 0);
    checkOutput("reset fzx5F", fzx5F, 0);
    checkOutput("reset switch", switchOut, 1);
    checkOutput("reset commit", commitOut, 0);
    tick();
  endtask

  // The monitor owns the expected queue's consumer side: every commit pulse must match one entry.
  always @(negedge clk) begin
    if (commitOut === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedCommit: got commit with outputs %h expected no commit",
                 {zxP, zxF, fzxP, fzxF, fzx2F, fzx3F, fzx4F, fzx5F});
      end else begin
        logic [127:0] expV;
        expV = expQ.pop_front();
        if ({zxP, zxF, fzxP, fzxF, fzx2F, fzx3F, fzx4F, fzx5F} !== expV) begin
          errors++;
          $display("[TB] FAIL commitValues: got %h expected %h",
                   {zxP, zxF, fzxP, fzxF, fzx2F, fzx3F, fzx4F, fzx5F}, expV);
        end
      end
    end
  end

  initial begin
    logic swExp [6];
    swExp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Single update on the sine channel.
    doReset();
    applyStimulus(1, 16'd387, 16'd345, 0, 0, 0, 0, 0);
    checkOutput("t1 zxReady", zxReady, 1);
    checkOutput("t1 fzxReady", fzxReady, 0);
    tick();
    expQ.push_back(packExp(387, 345, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("t1 commitEarly", commitOut, 0);
    checkOutput("t1 zxPHeld", zxP, 0);
    tick();
    checkOutput("t1 commit", commitOut, 1);
    tick();
    checkOutput("t1 commitOnce", commitOut, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Tie arbitration from reset: zx first, then fzx, one commit for both.
    doReset();
    applyStimulus(1, 16'd200, 16'd210, 1, 16'd100, 16'd480, H1, 0);
    checkOutput("t2 zxReadyTie", zxReady, 1);
    checkOutput("t2 fzxReadyTie", fzxReady, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 16'd100, 16'd480, H1, 0);
    checkOutput("t2 fzxReadyNext", fzxReady, 1);
    tick();
    expQ.push_back(packExp(200, 210, 100, 480, 0, 40, 0, 3));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    checkOutput("t2 fzx3F", fzx3F, 40);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Backpressure while the sine channel is pending.
    applyStimulus(1, 16'd387, 16'd345, 0, 0, 0, 0, 0);
    checkOutput("t3 firstReady", zxReady, 1);
    tick();
    expQ.push_back(packExp(387, 345, 100, 480, 0, 40, 0, 3));
    applyStimulus(1, 16'd500, 16'd123, 0, 0, 0, 0, 0);
    checkOutput("t3 blockedIdle", zxReady, 0);
    tick();
    checkOutput("t3 blockedArmed", zxReady, 0);
    applyStimulus(1, 16'd500, 16'd123, 0, 0, 0, 0, 1);
    tick();
    checkOutput("t3 blockedCommit", zxReady, 0);
    tick();
    checkOutput("t3 firstP", zxP, 387);
    checkOutput("t3 readyAfter", zxReady, 1);
    tick();
    expQ.push_back(packExp(500, 123, 100, 480, 0, 40, 0, 3));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    checkOutput("t3 secondP", zxP, 500);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Edge race: transfer on the rise edge joins the commit; one offered in COMMIT waits.
    applyStimulus(1, 16'd1, 16'd2, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 16'd7, 16'd8, H2, 1);
    checkOutput("t4 raceReady", fzxReady, 1);
    tick();
    expQ.push_back(packExp(1, 2, 7, 8, 1, 2, 3, 4));
    applyStimulus(1, 16'd9, 16'd10, 0, 0, 0, 0, 1);
    checkOutput("t4 commitStall", zxReady, 0);
    tick();
    checkOutput("t4 nextFrameReady", zxReady, 1);
    tick();
    expQ.push_back(packExp(9, 10, 7, 8, 1, 2, 3, 4));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // View switching over six idle frames.
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      checkOutput($sformatf("t5 switchRise%0d", i + 1), switchOut, swExp[i]);
      checkOutput($sformatf("t5 switchHold%0d", i + 1), switch0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end

    // Reset while ARMED with vblank held high.
    doReset();
    applyStimulus(1, 16'd55, 16'd66, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6 noCommitAfterReset", commitOut, 0);
    end
    checkOutput("t6 zxP", zxP, 0);
    checkOutput("t6 switch", switchOut, 1);
    applyStimulus(1, 16'd77, 16'd88, 0, 0, 0, 0, 1);
    tick();
    expQ.push_back(packExp(77, 88, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t6 noFalseRise", commitOut, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    tick();
    checkOutput("t6 commitAfterRealRise", commitOut, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    checkOutput("queueDrained", 64'(expQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_param_sched.md
DISP_PARAM_SCHED -- requirements
Module: disp_param_sched

Interface
REQ-001 The block SHALL have parameter HOLD_FRAMES, default 60, meaning frames per display view before `switch` toggles; the legal range is 1..255.
REQ-002 The block SHALL have parameter AUTO_SWITCH, default 1, meaning 1 = auto-toggle `switch`, 0 = hold `switch` at 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port vblank, input, 1 bit: high during vertical blanking, from the VGA timing generator.
REQ-006 The block SHALL have ports zx_valid (input, 1), zx_ready (output, 1), zx_p_in (input, 16) and zx_f_in (input, 16): the sine-channel producer port.
REQ-007 The block SHALL have ports fzx_valid (input, 1), fzx_ready (output, 1), fzx_p_in (input, 16), fzx_f_in (input, 16) and fzx_h_in (input, 64): the non-sine-channel producer port; fzx_h_in[15:0] is the 2nd harmonic, [31:16] the 3rd, [47:32] the 4th, [63:48] the 5th.
REQ-008 The block SHALL have outputs zx_P, zx_F, fzx_P, fzx_F, fzx_2_F, fzx_3_F, fzx_4_F and fzx_5_F, each 16 bits: registered display values feeding the display top.
REQ-009 The block SHALL have output switch, 1 bit: display view select.
REQ-010 The block SHALL have output commit, 1 bit: one-cycle pulse when the display values update.

Function
REQ-011 The block SHALL register vblank into vblank_d and define rise = vblank & ~vblank_d.
REQ-012 The block SHALL keep one 16-bit shadow register set and one pending flag per channel.
REQ-013 The block SHALL implement FSM states IDLE, ARMED and COMMIT.
- IDLE -> ARMED when any pending flag is set.
- ARMED -> COMMIT on rise.
- COMMIT -> IDLE unconditionally after 1 cycle.
REQ-014 The block SHALL accept a transfer on a channel when valid & ready are both high at a clock edge; inputs are captured into that channel's shadow and its pending flag is set on the same edge.
REQ-015 The block SHALL drive ready combinationally, high only when all of the following hold:
- state is IDLE or ARMED;
- the channel's pending flag is clear;
- the arbiter grants that channel.
REQ-016 Arbitration SHALL work as follows:
- If exactly one channel is eligible (valid & !pending), it is granted.
- If both are eligible, the channel not served last is granted; last-served updates on each accepted transfer.
- At most one transfer is accepted per cycle.
REQ-017 While in COMMIT, the block SHALL copy only pending channels' shadows to their outputs and clear all pending flags; outputs of non-pending channels SHALL hold their values.
REQ-018 The block SHALL assert commit for exactly the one cycle in which the new output values first appear, i.e. the cycle after COMMIT.
REQ-019 Latency: a transfer accepted in the same cycle as rise in state ARMED SHALL be included in that commit.
REQ-020 Latency: a transfer accepted after COMMIT is entered SHALL wait for the next rise.
REQ-021 A rise while in IDLE (nothing pending) SHALL cause no commit; a second rise while in ARMED is impossible by construction and needs no handling.
REQ-022 The frame counter SHALL be 8 bits, increment on every rise, and wrap to 0 after reaching HOLD_FRAMES-1.
REQ-023 When AUTO_SWITCH=1, switch SHALL toggle on the same edge as the wrap; when AUTO_SWITCH=0, switch SHALL stay 1.
REQ-024 With HOLD_FRAMES=1, switch SHALL toggle on every rise.
REQ-025 A switch toggle and a commit triggered by the same rise SHALL both take effect, with no ordering dependency between them.
REQ-026 Output values SHALL change only in the cycle after COMMIT, so they are updated only during blanking.

Reset
REQ-027 When rst is high at a clock edge, the block SHALL set:
- all 16-bit outputs to 0;
- commit to 0;
- switch to 1;
- frame counter to 0;
- pending flags to 0;
- shadows to 0;
- state to IDLE;
- last-served to fzx, so zx wins the first tie;
- vblank_d to 1, so no false rise is seen if vblank is high when reset is released.
REQ-028 zx_ready and fzx_ready SHALL be 0 while rst is high.
REQ-029 A reset in ARMED or COMMIT SHALL discard pending data; no commit pulse SHALL follow it.

Verification
REQ-030 The bench SHALL cover single update: zx_valid with zx_p_in=387, zx_f_in=345 in IDLE -> zx_ready=1, accepted; ARMED; on vblank rise, COMMIT; next cycle zx_P=387, zx_F=345, commit=1 for 1 cycle; fzx outputs remain 0.
REQ-031 The bench SHALL cover tie arbitration: both valid from reset -> zx accepted first cycle; fzx accepted next cycle (fzx_P=100, fzx_F=480, fzx_h_in={16'd3,16'd0,16'd40,16'd0}); one commit updates all 8 outputs; fzx_3_F=40, fzx_5_F=3.
REQ-032 The bench SHALL cover backpressure: a second zx_valid with zx_p_in=500 while zx is pending -> zx_ready=0 until the cycle after COMMIT; zx_P=387 after the first commit, 500 after the second.
REQ-033 The bench SHALL cover edge race: transfer accepted on the same edge as vblank rise in ARMED -> its values appear in that commit; a transfer offered during COMMIT stalls (ready=0) until the next frame.
REQ-034 The bench SHALL cover auto switch with HOLD_FRAMES=3: 6 vblank rises -> switch goes 1,1,0,0,0,1 after rises 1..6 (toggling at rises 3 and 6); with AUTO_SWITCH=0, switch stays 1.
REQ-035 The bench SHALL cover reset mid-operation: rst asserted in ARMED with vblank held high -> after release, outputs=0, switch=1, no commit pulse, and no rise is detected until vblank falls and rises again.
